// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared encodings for the execute stage
// Purpose: ALU op codes, multiply/divide op codes, forwarding selects,
//          memory access sizes and the multiply/divide FSM state type.
// Ports:   none (package).
package ex_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  localparam logic [1:0] FWD_ID  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] MEM_NONE     = 2'd0;
  localparam logic [1:0] MEM_BYTE     = 2'd1;
  localparam logic [1:0] MEM_HALFWORD = 2'd2;
  localparam logic [1:0] MEM_WORD     = 2'd3;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // True for the ops that launch an iterative multiply/divide.
  function automatic logic md_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// rtl/ex_stage_muldiv_unit.sv - iterative radix-2 multiply/divide with HI/LO
// Purpose: 32-cycle shift-add multiply and restoring divide on magnitudes,
//          sign-corrected on completion.
// Ports:   clk_i, n_rst_i (async, active-low); start_i/op_i/a_i/b_i issue an
//          op when idle; busy_o high while iterating; hi_o/lo_o results.
module ex_stage_muldiv_unit
  import ex_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_t   state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
  logic [31:0] dividend_q, dividend_d, mag_b_q, mag_b_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        is_signed, is_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod;

  always_comb begin
    is_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
    is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    mag_a     = (is_signed && a_i[31]) ? (32'd0 - a_i) : a_i;
    mag_b     = (is_signed && b_i[31]) ? (32'd0 - b_i) : b_i;
  end

  // One iteration. Multiply: acc_lo holds the multiplier and shifts right
  // while the partial product grows into acc_hi. Divide: acc_lo holds the
  // dividend shifting out into the remainder in acc_hi, quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    if (div_q) begin
      if (div_shift >= {1'b0, mag_b_q}) begin
        step_hi = div_shift[31:0] - mag_b_q;
        step_lo = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi = div_shift[31:0];
        step_lo = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
    prod = {step_hi, step_lo};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    div_d      = div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    dividend_d = dividend_q;
    mag_b_d    = mag_b_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d    = MD_BUSY;
          count_d    = 5'd31;
          div_d      = is_div;
          neg_d      = is_signed & (a_i[31] ^ b_i[31]);
          neg_rem_d  = is_signed & a_i[31];
          dbz_d      = is_div & (b_i == 32'd0);
          dividend_d = a_i;
          mag_b_d    = mag_b;
          acc_hi_d   = 32'd0;
          acc_lo_d   = mag_a;
        end
      end
      MD_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q - 5'd1;
        if (count_q == 5'd0) begin
          state_d = MD_IDLE;
          if (!div_q) begin
            {hi_d, lo_d} = neg_q ? (64'd0 - prod) : prod;
          end else if (dbz_q) begin
            hi_d = dividend_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = neg_q ? (32'd0 - step_lo) : step_lo;
            hi_d = neg_rem_q ? (32'd0 - step_hi) : step_hi;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= MD_IDLE;
      count_q    <= 5'd0;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      dividend_q <= 32'd0;
      mag_b_q    <= 32'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      div_q      <= div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
      dividend_q <= dividend_d;
      mag_b_q    <= mag_b_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy_o = (state_q == MD_BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage with EX/MEM pipeline register
// Purpose: operand forwarding, ALU, branch target, EX/MEM register and
//          (with EX_MULDIV_EN defined) the multiply/divide unit and stall.
// Ports:   clk_i, n_rst_i (async, active-low); IDEX_* decoded instruction;
//          fwd_* forwarding selects/values; EXMEM_* registered outputs;
//          EX_stall_o combinational hold request to upstream stages.
// Config:  EX_MULDIV_EN enables the multiply/divide unit and HI/LO.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic [DATA_W-1:0] IDEX_pc_next_i,
  input  logic [DATA_W-1:0] IDEX_a_i,
  input  logic [DATA_W-1:0] IDEX_b_i,
  input  logic [DATA_W-1:0] IDEX_imm_i,
  input  logic [4:0]        IDEX_rt_i,
  input  logic [4:0]        IDEX_rd_i,
  input  logic [3:0]        IDEX_ctrl_alu_op_i,
  input  logic              IDEX_ctrl_alu_src_i,
  input  logic              IDEX_ctrl_reg_dst_i,
  input  logic              IDEX_ctrl_branch_i,
  input  logic [1:0]        IDEX_ctrl_mem_read_i,
  input  logic [1:0]        IDEX_ctrl_mem_write_i,
  input  logic              IDEX_ctrl_reg_write_i,
  input  logic              IDEX_ctrl_mem_to_reg_i,
  input  logic [2:0]        IDEX_ctrl_muldiv_i,
  input  logic [1:0]        fwd_a_sel_i,
  input  logic [1:0]        fwd_b_sel_i,
  input  logic [DATA_W-1:0] fwd_mem_i,
  input  logic [DATA_W-1:0] fwd_wb_i,
  output logic [DATA_W-1:0] EXMEM_pc_branch_o,
  output logic [DATA_W-1:0] EXMEM_alu_o,
  output logic              EXMEM_alu_do_branch_o,
  output logic [DATA_W-1:0] EXMEM_b_o,
  output logic [4:0]        EXMEM_rd_o,
  output logic              EXMEM_ctrl_branch_o,
  output logic              EXMEM_ctrl_reg_write_o,
  output logic              EXMEM_ctrl_mem_to_reg_o,
  output logic [1:0]        EXMEM_ctrl_mem_read_o,
  output logic [1:0]        EXMEM_ctrl_mem_write_o,
  output logic              EX_stall_o
);

  logic [31:0] op_a, op_b_reg, op_b, alu_res, ex_result, pc_branch, hi, lo;
  logic        md_start, kill_m2r;

  always_comb begin
    case (fwd_a_sel_i)
      FWD_MEM: op_a = fwd_mem_i;
      FWD_WB:  op_a = fwd_wb_i;
      default: op_a = IDEX_a_i;
    endcase
    case (fwd_b_sel_i)
      FWD_MEM: op_b_reg = fwd_mem_i;
      FWD_WB:  op_b_reg = fwd_wb_i;
      default: op_b_reg = IDEX_b_i;
    endcase
    op_b = IDEX_ctrl_alu_src_i ? IDEX_imm_i : op_b_reg;
  end

  always_comb begin
    alu_res = 32'd0;
    case (IDEX_ctrl_alu_op_i)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, op_a < op_b};
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
      ALU_LUI:  alu_res = {IDEX_imm_i[15:0], 16'd0};
      default:  alu_res = 32'd0;
    endcase
  end

  always_comb begin
    case (IDEX_ctrl_muldiv_i)
      MD_MFHI: ex_result = hi;
      MD_MFLO: ex_result = lo;
      default: ex_result = alu_res;
    endcase
  end

  assign pc_branch = IDEX_pc_next_i + {IDEX_imm_i[29:0], 2'b00};
  assign md_start  = md_is_start(IDEX_ctrl_muldiv_i);

`ifdef EX_MULDIV_EN
  logic md_busy;

  // The unit only accepts an op while idle; a start op arriving while busy
  // is held upstream by the stall until the unit drains.
  ex_stage_muldiv_unit u_muldiv (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .start_i (md_start),
    .op_i    (IDEX_ctrl_muldiv_i),
    .a_i     (op_a),
    .b_i     (op_b_reg),
    .busy_o  (md_busy),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign EX_stall_o = md_busy & (IDEX_ctrl_muldiv_i != MD_NONE);
  assign kill_m2r   = 1'b0;
`else
  assign hi         = 32'd0;
  assign lo         = 32'd0;
  assign EX_stall_o = 1'b0;
  // Without the unit a muldiv start op is a complete bubble.
  assign kill_m2r   = md_start;
`endif

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      EXMEM_pc_branch_o       <= '0;
      EXMEM_alu_o             <= '0;
      EXMEM_alu_do_branch_o   <= 1'b0;
      EXMEM_b_o               <= '0;
      EXMEM_rd_o              <= 5'd0;
      EXMEM_ctrl_branch_o     <= 1'b0;
      EXMEM_ctrl_reg_write_o  <= 1'b0;
      EXMEM_ctrl_mem_to_reg_o <= 1'b0;
      EXMEM_ctrl_mem_read_o   <= 2'd0;
      EXMEM_ctrl_mem_write_o  <= 2'd0;
    end else if (EX_stall_o) begin
      // Bubble: controls cleared, data held.
      EXMEM_ctrl_branch_o     <= 1'b0;
      EXMEM_ctrl_reg_write_o  <= 1'b0;
      EXMEM_ctrl_mem_to_reg_o <= 1'b0;
      EXMEM_ctrl_mem_read_o   <= 2'd0;
      EXMEM_ctrl_mem_write_o  <= 2'd0;
    end else begin
      EXMEM_pc_branch_o       <= pc_branch;
      EXMEM_alu_o             <= ex_result;
      EXMEM_alu_do_branch_o   <= (ex_result == 32'd0);
      EXMEM_b_o               <= op_b_reg;
      EXMEM_rd_o              <= IDEX_ctrl_reg_dst_i ? IDEX_rd_i : IDEX_rt_i;
      EXMEM_ctrl_branch_o     <= IDEX_ctrl_branch_i & ~md_start;
      EXMEM_ctrl_reg_write_o  <= IDEX_ctrl_reg_write_i & ~md_start;
      EXMEM_ctrl_mem_to_reg_o <= IDEX_ctrl_mem_to_reg_i & ~kill_m2r;
      EXMEM_ctrl_mem_read_o   <= md_start ? 2'd0 : IDEX_ctrl_mem_read_i;
      EXMEM_ctrl_mem_write_o  <= md_start ? 2'd0 : IDEX_ctrl_mem_write_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed scoreboard bench for ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rt, rd;
    logic [3:0]  alu_op;
    logic        alu_src, reg_dst, branch;
    logic [1:0]  mr, mw;
    logic        rw, m2r;
    logic [2:0]  md;
    logic [1:0]  fa, fb;
    logic [31:0] fmem, fwb;
  } instr_t;

  typedef struct {
    string       tag;
    logic        chk_data;
    logic [31:0] alu, pcb, b;
    logic        zero;
    logic [4:0]  rd;
    logic [6:0]  ctrl;
  } exp_t;

  logic        clk_i, n_rst_i;
  logic [31:0] IDEX_pc_next_i, IDEX_a_i, IDEX_b_i, IDEX_imm_i;
  logic [4:0]  IDEX_rt_i, IDEX_rd_i;
  logic [3:0]  IDEX_ctrl_alu_op_i;
  logic        IDEX_ctrl_alu_src_i, IDEX_ctrl_reg_dst_i, IDEX_ctrl_branch_i;
  logic [1:0]  IDEX_ctrl_mem_read_i, IDEX_ctrl_mem_write_i;
  logic        IDEX_ctrl_reg_write_i, IDEX_ctrl_mem_to_reg_i;
  logic [2:0]  IDEX_ctrl_muldiv_i;
  logic [1:0]  fwd_a_sel_i, fwd_b_sel_i;
  logic [31:0] fwd_mem_i, fwd_wb_i;
  logic [31:0] EXMEM_pc_branch_o, EXMEM_alu_o, EXMEM_b_o;
  logic        EXMEM_alu_do_branch_o;
  logic [4:0]  EXMEM_rd_o;
  logic        EXMEM_ctrl_branch_o, EXMEM_ctrl_reg_write_o, EXMEM_ctrl_mem_to_reg_o;
  logic [1:0]  EXMEM_ctrl_mem_read_o, EXMEM_ctrl_mem_write_o;
  logic        EX_stall_o;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  ex_stage dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i),
    .IDEX_pc_next_i(IDEX_pc_next_i), .IDEX_a_i(IDEX_a_i), .IDEX_b_i(IDEX_b_i),
    .IDEX_imm_i(IDEX_imm_i), .IDEX_rt_i(IDEX_rt_i), .IDEX_rd_i(IDEX_rd_i),
    .IDEX_ctrl_alu_op_i(IDEX_ctrl_alu_op_i), .IDEX_ctrl_alu_src_i(IDEX_ctrl_alu_src_i),
    .IDEX_ctrl_reg_dst_i(IDEX_ctrl_reg_dst_i), .IDEX_ctrl_branch_i(IDEX_ctrl_branch_i),
    .IDEX_ctrl_mem_read_i(IDEX_ctrl_mem_read_i), .IDEX_ctrl_mem_write_i(IDEX_ctrl_mem_write_i),
    .IDEX_ctrl_reg_write_i(IDEX_ctrl_reg_write_i), .IDEX_ctrl_mem_to_reg_i(IDEX_ctrl_mem_to_reg_i),
    .IDEX_ctrl_muldiv_i(IDEX_ctrl_muldiv_i),
    .fwd_a_sel_i(fwd_a_sel_i), .fwd_b_sel_i(fwd_b_sel_i),
    .fwd_mem_i(fwd_mem_i), .fwd_wb_i(fwd_wb_i),
    .EXMEM_pc_branch_o(EXMEM_pc_branch_o), .EXMEM_alu_o(EXMEM_alu_o),
    .EXMEM_alu_do_branch_o(EXMEM_alu_do_branch_o), .EXMEM_b_o(EXMEM_b_o),
    .EXMEM_rd_o(EXMEM_rd_o), .EXMEM_ctrl_branch_o(EXMEM_ctrl_branch_o),
    .EXMEM_ctrl_reg_write_o(EXMEM_ctrl_reg_write_o),
    .EXMEM_ctrl_mem_to_reg_o(EXMEM_ctrl_mem_to_reg_o),
    .EXMEM_ctrl_mem_read_o(EXMEM_ctrl_mem_read_o),
    .EXMEM_ctrl_mem_write_o(EXMEM_ctrl_mem_write_o),
    .EX_stall_o(EX_stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '0;
    i.alu_op = ALU_ADD;
    i.md     = MD_NONE;
    return i;
  endfunction

  function automatic instr_t alu_i(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = nop();
    i.alu_op = op; i.a = a; i.b = b; i.rw = 1'b1; i.reg_dst = 1'b1; i.rd = 5'd3; i.rt = 5'd9;
    return i;
  endfunction

  function automatic instr_t md_i(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = alu_i(ALU_ADD, a, b);
    i.md = op;
    return i;
  endfunction

  function automatic exp_t model(input string tag, input instr_t i, input logic chk_data, input logic [31:0] alu);
    exp_t e;
    logic kill;
    kill = (i.md == MD_MULT) || (i.md == MD_MULTU) || (i.md == MD_DIV) || (i.md == MD_DIVU);
    e.tag = tag; e.chk_data = chk_data; e.alu = alu; e.zero = (alu == 32'd0);
    e.pcb = i.pc + (i.imm << 2);
    e.b   = (i.fb == FWD_MEM) ? i.fmem : (i.fb == FWD_WB) ? i.fwb : i.b;
    e.rd  = i.reg_dst ? i.rd : i.rt;
`ifdef EX_MULDIV_EN
    e.ctrl = kill ? {2'b00, i.m2r, 4'b0000} : {i.branch, i.rw, i.m2r, i.mr, i.mw};
`else
    e.ctrl = kill ? 7'd0 : {i.branch, i.rw, i.m2r, i.mr, i.mw};
`endif
    return e;
  endfunction

  task automatic apply(input instr_t i);
    IDEX_pc_next_i = i.pc; IDEX_a_i = i.a; IDEX_b_i = i.b; IDEX_imm_i = i.imm;
    IDEX_rt_i = i.rt; IDEX_rd_i = i.rd; IDEX_ctrl_alu_op_i = i.alu_op;
    IDEX_ctrl_alu_src_i = i.alu_src; IDEX_ctrl_reg_dst_i = i.reg_dst;
    IDEX_ctrl_branch_i = i.branch; IDEX_ctrl_mem_read_i = i.mr; IDEX_ctrl_mem_write_i = i.mw;
    IDEX_ctrl_reg_write_i = i.rw; IDEX_ctrl_mem_to_reg_i = i.m2r; IDEX_ctrl_muldiv_i = i.md;
    fwd_a_sel_i = i.fa; fwd_b_sel_i = i.fb; fwd_mem_i = i.fmem; fwd_wb_i = i.fwb;
  endtask

  task automatic check_out(input exp_t e);
    if (e.chk_data) begin
      chk({e.tag, " alu"}, EXMEM_alu_o, e.alu);
      chk({e.tag, " zero"}, {31'd0, EXMEM_alu_do_branch_o}, {31'd0, e.zero});
      chk({e.tag, " pcb"}, EXMEM_pc_branch_o, e.pcb);
      chk({e.tag, " b"}, EXMEM_b_o, e.b);
      chk({e.tag, " rd"}, {27'd0, EXMEM_rd_o}, {27'd0, e.rd});
    end
    chk({e.tag, " ctrl"},
        {25'd0, EXMEM_ctrl_branch_o, EXMEM_ctrl_reg_write_o, EXMEM_ctrl_mem_to_reg_o,
         EXMEM_ctrl_mem_read_o, EXMEM_ctrl_mem_write_o}, {25'd0, e.ctrl});
  endtask

  // Present one instruction for one cycle; a stalled cycle must yield a bubble.
  task automatic step(input string tag, input instr_t i, input logic exp_stall,
                      input logic chk_data, input logic [31:0] alu);
    exp_t e;
    apply(i);
    #1;
    chk({tag, " stall"}, {31'd0, EX_stall_o}, {31'd0, exp_stall});
    if (exp_stall) begin
      e = model(tag, nop(), 1'b0, 32'd0);
      e.ctrl = 7'd0;
    end else begin
      e = model(tag, i, chk_data, alu);
    end
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    check_out(sb.pop_front());
  endtask

  task automatic check_reset(input string tag);
    exp_t e;
    e = model(tag, nop(), 1'b1, 32'd0);
    e.zero = 1'b0;
    e.ctrl = 7'd0;
    chk({tag, " stall"}, {31'd0, EX_stall_o}, 32'd0);
    check_out(e);
  endtask

  initial begin
    instr_t i, m;
    n_rst_i = 1'b0;
    apply(nop());
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("reset");
    n_rst_i = 1'b1;

    // ALU and flag
    i = alu_i(ALU_ADD, 32'd5, 32'hFFFF_FFFF);           step("add_wrap", i, 0, 1, 32'd4);
    i = alu_i(ALU_SUB, 32'd7, 32'd7); i.reg_dst = 1'b0; step("sub_zero", i, 0, 1, 32'd0);
    i = alu_i(ALU_SUB, 32'd0, 32'd1);                   step("sub_wrap", i, 0, 1, 32'hFFFF_FFFF);
    i = alu_i(ALU_SLT, 32'hFFFF_FFFF, 32'd1);           step("slt", i, 0, 1, 32'd1);
    i = alu_i(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);          step("sltu", i, 0, 1, 32'd0);
    i = alu_i(ALU_SRA, 32'h8000_0000, 32'd4);           step("sra", i, 0, 1, 32'hF800_0000);
    i = alu_i(ALU_SRL, 32'h8000_0000, 32'd4);           step("srl", i, 0, 1, 32'h0800_0000);
    i = alu_i(ALU_SLL, 32'd1, 32'd31);                  step("sll", i, 0, 1, 32'h8000_0000);
    i = alu_i(ALU_NOR, 32'd0, 32'd0);                   step("nor", i, 0, 1, 32'hFFFF_FFFF);
    i = alu_i(ALU_XOR, 32'hF0F0, 32'hFF00);             step("xor", i, 0, 1, 32'h0FF0);
    i = alu_i(ALU_AND, 32'hF0F0, 32'hFF00);             step("and", i, 0, 1, 32'hF000);
    i = alu_i(ALU_LUI, 32'd0, 32'd0); i.alu_src = 1'b1; i.imm = 32'h1234;
    step("lui", i, 0, 1, 32'h1234_0000);

    // branch target
    i = alu_i(ALU_SUB, 32'd9, 32'd9); i.rw = 1'b0; i.branch = 1'b1;
    i.pc = 32'h100; i.imm = 32'hFFFF_FFFE;
    step("beq", i, 0, 1, 32'd0);
    chk("beq target", EXMEM_pc_branch_o, 32'hF8);
    chk("beq branch", {31'd0, EXMEM_ctrl_branch_o}, 32'd1);

    // forwarding
    i = alu_i(ALU_OR, 32'hDEAD, 32'd0); i.fa = FWD_MEM; i.fmem = 32'h10;
    i.alu_src = 1'b1; i.imm = 32'd3;
    step("fwd_or", i, 0, 1, 32'h13);
    i = alu_i(ALU_ADD, 32'h100, 32'h1111); i.rw = 1'b0; i.alu_src = 1'b1; i.imm = 32'd8;
    i.fb = FWD_WB; i.fwb = 32'hCAFE_F00D; i.mw = MEM_WORD;
    step("store", i, 0, 1, 32'h108);
    chk("store data", EXMEM_b_o, 32'hCAFE_F00D);

`ifdef EX_MULDIV_EN
    i = md_i(MD_MULT, 32'hFFFF_FFFD, 32'd7); i.branch = 1'b1; i.mr = MEM_WORD;
    step("mult_issue", i, 0, 0, 32'd0);
    m = md_i(MD_MFLO, 32'd0, 32'd0); m.rd = 5'd8;
    for (int k = 0; k < 32; k++) step("mflo_stall", m, 1, 0, 32'd0);
    step("mflo_mult", m, 0, 1, 32'hFFFF_FFEB);
    m.md = MD_MFHI; step("mfhi_mult", m, 0, 1, 32'hFFFF_FFFF);

    step("divu_issue", md_i(MD_DIVU, 32'd100, 32'd0), 0, 0, 32'd0);
    for (int k = 0; k < 32; k++) step("add_busy", alu_i(ALU_ADD, 32'(k), 32'd1), 0, 1, 32'(k + 1));
    m.md = MD_MFLO; step("divu0_lo", m, 0, 1, 32'hFFFF_FFFF);
    m.md = MD_MFHI; step("divu0_hi", m, 0, 1, 32'd100);

    step("div_issue", md_i(MD_DIV, 32'hFFFF_FFF9, 32'd2), 0, 0, 32'd0);
    for (int k = 0; k < 31; k++) step("nop_busy", nop(), 0, 1, 32'd0);
    m.md = MD_MFLO; step("mflo_last", m, 1, 0, 32'd0);
    step("div_lo", m, 0, 1, 32'hFFFF_FFFD);
    m.md = MD_MFHI; step("div_hi", m, 0, 1, 32'hFFFF_FFFF);

    step("multu_issue", md_i(MD_MULTU, 32'd2, 32'd3), 0, 0, 32'd0);
    for (int k = 0; k < 31; k++) step("nop_busy2", nop(), 0, 1, 32'd0);
    step("multu_late", md_i(MD_MULTU, 32'd5, 32'd5), 1, 0, 32'd0);
    step("multu_issue2", md_i(MD_MULTU, 32'd5, 32'd5), 0, 0, 32'd0);
    m.md = MD_MFLO;
    for (int k = 0; k < 32; k++) step("mflo_stall2", m, 1, 0, 32'd0);
    step("multu_lo", m, 0, 1, 32'd25);
    m.md = MD_MFHI; step("multu_hi", m, 0, 1, 32'd0);

    step("mult_rst_issue", md_i(MD_MULT, 32'h1234_5678, 32'd3), 0, 0, 32'd0);
    for (int k = 0; k < 10; k++) step("nop_busy3", nop(), 0, 1, 32'd0);
    apply(m);
    #1;
    chk("stall_before_rst", {31'd0, EX_stall_o}, 32'd1);
`else
    i = md_i(MD_MULT, 32'hFFFF_FFFD, 32'd7); i.branch = 1'b1; i.mr = MEM_WORD;
    step("mult_bubble", i, 0, 0, 32'd0);
    m = md_i(MD_MFLO, 32'd0, 32'd0); m.rd = 5'd8;
    step("mflo_zero", m, 0, 1, 32'd0);
    m.md = MD_MFHI; step("mfhi_zero", m, 0, 1, 32'd0);
    step("divu_bubble", md_i(MD_DIVU, 32'd100, 32'd0), 0, 0, 32'd0);
    step("add_pre_rst", alu_i(ALU_ADD, 32'd1, 32'd1), 0, 1, 32'd2);
    apply(m);
    #1;
`endif
    n_rst_i = 1'b0;
    #1;
    check_reset("rst_mid");
    @(posedge clk_i);
    #1;
    n_rst_i = 1'b1;
    m.md = MD_MFHI; step("mfhi_after_rst", m, 0, 1, 32'd0);
    m.md = MD_MFLO; step("mflo_after_rst", m, 0, 1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
